// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of NUM_COUNTERS event counters behind a 32-bit register port.
//   Each counter counts one of NUM_EVENTS per-cycle strobes.
//   A counter counts only while both its own enable and the global enable are set.
//   On wrap from all-ones to zero, a counter sets a sticky overflow flag; that flag can raise an interrupt.
//   Reads are atomic: reading VALUE_LO latches the upper word into a per-counter shadow, and VALUE_HI returns that shadow.
// Ports:
//   clk, reset          : core clock, synchronous active-high reset
//   perf_events         : one-cycle event strobes, bit e = event e
//   reg_write_en/_read_en, reg_addr, reg_write_data : register access
//   reg_read_data       : read data, valid the cycle after reg_read_en, held otherwise
//   overflow_int        : registered interrupt request
// Register map, per counter i at base i*8:
//   +0 CTRL      : bit0 enable, bit1 overflow irq enable, bit2 threshold irq enable (*), bits[8+:SEL_W] event select
//   +1 VALUE_LO
//   +2 VALUE_HI  : returns the shadow
//   +3 STATUS    : bit0 overflow, bit1 threshold (*); both W1C
//   +4/+5 THRESH_LO/HI (*)
//   0xF8 GLOBAL_CTRL : bit0 global enable
//   0xF9 OVF_SUMMARY : read-only
// (*) These fields exist only when compiled with the macro PERF_THRESHOLD_EN.
//     Without it they read 0.
module perf_counter_bank #(
  parameter int NUM_EVENTS    = 8,
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic                  reg_write_en,
  input  logic                  reg_read_en,
  input  logic [7:0]            reg_addr,
  input  logic [31:0]           reg_write_data,
  output logic [31:0]           reg_read_data,
  output logic                  overflow_int
);

  localparam int EVSEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  // The select field gets one extra bit so that out-of-range selects stay representable.
  // For example, with NUM_EVENTS = 8 a select of 9 is stored as 9 and never counts.
  localparam int SEL_W = EVSEL_W + 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic                     global_en;
  logic [NUM_COUNTERS-1:0]  ctrl_en, ctrl_ie, ovf, ovf_nxt, inc;
  logic [SEL_W-1:0]         ctrl_sel [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt      [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_nxt  [NUM_COUNTERS];
  logic [63:0]              cnt_ext  [NUM_COUNTERS];
  logic [31:0]              shadow   [NUM_COUNTERS];
  logic [31:0]              rdata;
  logic [4:0]               cidx;
  logic [2:0]               off;
`ifdef PERF_THRESHOLD_EN
  logic [NUM_COUNTERS-1:0]  ctrl_tie, thf, thf_nxt;
  logic [COUNTER_WIDTH-1:0] thr      [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] thr_nxt  [NUM_COUNTERS];
  logic [63:0]              thr_ext  [NUM_COUNTERS];
`endif

  assign cidx = reg_addr[7:3];
  assign off  = reg_addr[2:0];

  function automatic logic sel_hit(input logic [SEL_W-1:0] sel, input logic [NUM_EVENTS-1:0] ev);
    logic h;
    h = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++)
      if (sel == SEL_W'(e) && ev[e]) h = 1'b1;
    return h;
  endfunction

  function automatic logic cwr(input logic [4:0] idx, input logic [2:0] o, input int i, input int k);
    return idx == 5'(i) && o == 3'(k);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_ext[i] = 64'(cnt[i]);
      cnt_nxt[i] = cnt[i];
      ovf_nxt[i] = ovf[i];
      inc[i]     = global_en & ctrl_en[i] & sel_hit(ctrl_sel[i], perf_events);
`ifdef PERF_THRESHOLD_EN
      thr_ext[i] = 64'(thr[i]);
      thr_nxt[i] = thr[i];
      thf_nxt[i] = thf[i];
      if (reg_write_en && cwr(cidx, off, i, 3) && reg_write_data[1]) thf_nxt[i] = 1'b0;
`endif
      // Clear first so that an overflow in the same cycle wins.
      if (reg_write_en && cwr(cidx, off, i, 3) && reg_write_data[0]) ovf_nxt[i] = 1'b0;
      if (reg_write_en && (cwr(cidx, off, i, 1) || cwr(cidx, off, i, 2))) begin
        // A value write takes priority and drops any increment in the same cycle.
        // Bit b comes from reg_write_data[b % 32]: LO supplies bits 31:0 and HI supplies the bits above.
        for (int b = 0; b < COUNTER_WIDTH; b++)
          if ((b < 32) ? (off == 3'd1) : (off == 3'd2)) cnt_nxt[i][b] = reg_write_data[b % 32];
      end else if (inc[i]) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
        if (cnt[i] == CNT_MAX) ovf_nxt[i] = 1'b1;
`ifdef PERF_THRESHOLD_EN
        if (COUNTER_WIDTH'(cnt[i] + 1'b1) == thr[i]) thf_nxt[i] = 1'b1;
`endif
      end
`ifdef PERF_THRESHOLD_EN
      if (reg_write_en && (cwr(cidx, off, i, 4) || cwr(cidx, off, i, 5))) begin
        for (int b = 0; b < COUNTER_WIDTH; b++)
          if ((b < 32) ? (off == 3'd4) : (off == 3'd5)) thr_nxt[i][b] = reg_write_data[b % 32];
      end
`endif
    end
  end

  // The read mux uses only current register state.
  // A read and a write to the same address in one cycle therefore returns the pre-write value.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (cidx == 5'(i)) begin
        case (off)
          3'd0: begin
            rdata[0] = ctrl_en[i];
            rdata[1] = ctrl_ie[i];
`ifdef PERF_THRESHOLD_EN
            rdata[2] = ctrl_tie[i];
`endif
            rdata[8 +: SEL_W] = ctrl_sel[i];
          end
          3'd1: rdata = cnt_ext[i][31:0];
          3'd2: rdata = shadow[i];
          3'd3: begin
            rdata[0] = ovf[i];
`ifdef PERF_THRESHOLD_EN
            rdata[1] = thf[i];
`endif
          end
`ifdef PERF_THRESHOLD_EN
          3'd4: rdata = thr_ext[i][31:0];
          3'd5: rdata = thr_ext[i][63:32];
`endif
          default: ;
        endcase
      end
    end
    if (reg_addr == 8'hF8) rdata[0] = global_en;
    if (reg_addr == 8'hF9) rdata = 32'(ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      global_en     <= 1'b0;
      ctrl_en       <= '0;
      ctrl_ie       <= '0;
      ovf           <= '0;
      reg_read_data <= '0;
      overflow_int  <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        ctrl_sel[i] <= '0;
        cnt[i]      <= '0;
        shadow[i]   <= '0;
      end
`ifdef PERF_THRESHOLD_EN
      ctrl_tie <= '0;
      thf      <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) thr[i] <= '0;
`endif
    end else begin
      if (reg_write_en && reg_addr == 8'hF8) global_en <= reg_write_data[0];
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (reg_write_en && cwr(cidx, off, i, 0)) begin
          ctrl_en[i]  <= reg_write_data[0];
          ctrl_ie[i]  <= reg_write_data[1];
          ctrl_sel[i] <= reg_write_data[8 +: SEL_W];
`ifdef PERF_THRESHOLD_EN
          ctrl_tie[i] <= reg_write_data[2];
`endif
        end
        if (reg_read_en && cwr(cidx, off, i, 1)) shadow[i] <= cnt_ext[i][63:32];
`ifdef PERF_THRESHOLD_EN
        thr[i] <= thr_nxt[i];
`endif
      end
      ovf <= ovf_nxt;
      if (reg_read_en) reg_read_data <= rdata;
`ifdef PERF_THRESHOLD_EN
      overflow_int <= |(ovf & ctrl_ie) | |(thf & ctrl_tie);
      thf <= thf_nxt;
`else
      overflow_int <= |(ovf & ctrl_ie);
`endif
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  localparam int NE = 8;
  localparam int NC = 4;
  localparam int CW = 48;
  localparam longint unsigned MAXV = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] perf_events;
  logic          reg_write_en, reg_read_en;
  logic [7:0]    reg_addr;
  logic [31:0]   reg_write_data;
  logic [31:0]   reg_read_data;
  logic          overflow_int;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .perf_events(perf_events),
    .reg_write_en(reg_write_en), .reg_read_en(reg_read_en), .reg_addr(reg_addr),
    .reg_write_data(reg_write_data), .reg_read_data(reg_read_data), .overflow_int(overflow_int)
  );

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned m_cnt [NC];
  longint unsigned m_thr [NC];
  bit              m_en [NC], m_ie [NC], m_tie [NC], m_ovf [NC], m_thf [NC];
  int              m_sel [NC];
  logic [31:0]     m_shadow [NC];
  bit              m_gen;
  logic [31:0]     m_rd;
  bit              m_int;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_thr[i] = 0; m_en[i] = 0; m_ie[i] = 0; m_tie[i] = 0;
      m_ovf[i] = 0; m_thf[i] = 0; m_sel[i] = 0; m_shadow[i] = 0;
    end
    m_gen = 0; m_rd = 0; m_int = 0;
  endtask

  // One clock of the architectural rules, applied to the inputs presented in that cycle.
  task automatic model_step(input logic [7:0] ev, input bit we, input bit re,
                            input logic [7:0] a, input logic [31:0] wd);
    int ci, off;
    bit cm, nxt_int;
    logic [31:0] sh [NC];
    ci = int'(a) / 8;
    off = int'(a) % 8;
    cm = ci < NC;
    sh = m_shadow;
    nxt_int = 0;
    for (int i = 0; i < NC; i++)
      nxt_int |= (m_ovf[i] && m_ie[i]) || (m_thf[i] && m_tie[i]);
    if (re) begin
      m_rd = 0;
      if (cm) begin
        case (off)
          0: m_rd = {20'd0, 4'(m_sel[ci]), 5'd0, m_tie[ci], m_ie[ci], m_en[ci]};
          1: begin m_rd = m_cnt[ci][31:0]; sh[ci] = m_cnt[ci][63:32]; end
          2: m_rd = m_shadow[ci];
          3: m_rd = {30'd0, m_thf[ci], m_ovf[ci]};
`ifdef PERF_THRESHOLD_EN
          4: m_rd = m_thr[ci][31:0];
          5: m_rd = m_thr[ci][63:32];
`endif
          default: m_rd = 0;
        endcase
      end else if (a == 8'hF8) m_rd = {31'd0, m_gen};
      else if (a == 8'hF9) for (int i = 0; i < NC; i++) m_rd[i] = m_ovf[i];
    end
    for (int i = 0; i < NC; i++) begin
      bit hitv, mine, wrap, thit;
      hitv = m_gen && m_en[i] && (m_sel[i] < NE) && ev[m_sel[i]];
      mine = we && cm && (ci == i);
      wrap = 0;
      thit = 0;
      if (mine && off == 1)      m_cnt[i] = (((m_cnt[i] >> 32) << 32) | 64'(wd)) & MAXV;
      else if (mine && off == 2) m_cnt[i] = ((64'(wd) << 32) | (m_cnt[i] & 64'hFFFF_FFFF)) & MAXV;
      else if (hitv) begin
        wrap = (m_cnt[i] == MAXV);
        m_cnt[i] = wrap ? 64'd0 : m_cnt[i] + 1;
        thit = (m_cnt[i] == m_thr[i]);
      end
      if (mine && off == 3 && wd[0]) m_ovf[i] = 0;
      if (wrap) m_ovf[i] = 1;
`ifdef PERF_THRESHOLD_EN
      if (mine && off == 3 && wd[1]) m_thf[i] = 0;
      if (thit) m_thf[i] = 1;
      if (mine && off == 4) m_thr[i] = (((m_thr[i] >> 32) << 32) | 64'(wd)) & MAXV;
      if (mine && off == 5) m_thr[i] = ((64'(wd) << 32) | (m_thr[i] & 64'hFFFF_FFFF)) & MAXV;
      if (mine && off == 0) m_tie[i] = wd[2];
`endif
      if (mine && off == 0) begin
        m_en[i] = wd[0];
        m_ie[i] = wd[1];
        m_sel[i] = int'((wd >> 8) & 32'hF);
      end
    end
    if (we && a == 8'hF8) m_gen = wd[0];
    m_shadow = sh;
    m_int = nxt_int;
  endtask

  task automatic tick(input logic [7:0] ev, input bit we, input bit re,
                      input logic [7:0] a, input logic [31:0] wd);
    perf_events = ev; reg_write_en = we; reg_read_en = re; reg_addr = a; reg_write_data = wd;
    model_step(ev, we, re, a, wd);
    @(negedge clk);
    chk("rd_data", reg_read_data, m_rd);
    chk("ovf_int", overflow_int, m_int);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    tick(8'h00, 1, 0, a, d);
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
    tick(8'h00, 0, 1, a, 32'h0);
    chk(tag, reg_read_data, exp);
  endtask

  task automatic do_reset();
    reset = 1; perf_events = 0; reg_write_en = 0; reg_read_en = 0; reg_addr = 0; reg_write_data = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    chk("rst_rd", reg_read_data, 32'h0);
    chk("rst_int", overflow_int, 1'b0);
  endtask

  initial begin
    logic [7:0]  ra, ev;
    logic [31:0] rw;
    bit          we, re;

    do_reset();
    rd(8'h01, "rst_val_lo", 0);
    rd(8'hF8, "rst_global", 0);
    rd(8'h00, "rst_ctrl", 0);

    // event select and gating
    wr(8'hF8, 1);
    wr(8'h00, 32'h0201);
    repeat (5) tick(8'h04, 0, 0, 0, 0);
    repeat (3) tick(8'h02, 0, 0, 0, 0);
    rd(8'h01, "evsel_cnt0", 5);
    rd(8'h09, "disabled_cnt1", 0);

    // wrap and interrupt latency
    wr(8'h02, 32'hFFFF);
    wr(8'h01, 32'hFFFF_FFFE);
    wr(8'h00, 32'h0003);
    tick(8'h01, 0, 0, 0, 0);
    tick(8'h01, 0, 0, 0, 0);
    chk("wrap_int_lag", overflow_int, 1'b0);
    tick(8'h00, 0, 0, 0, 0);
    chk("wrap_int", overflow_int, 1'b1);
    rd(8'h01, "wrap_val", 0);
    rd(8'h03, "wrap_status", 1);
    rd(8'hF9, "ovf_summary", 1);

    // clear, then clear colliding with a new wrap
    wr(8'h03, 1);
    chk("clr_int_lag", overflow_int, 1'b1);
    tick(8'h00, 0, 0, 0, 0);
    chk("clr_int", overflow_int, 1'b0);
    wr(8'h02, 32'hFFFF); wr(8'h01, 32'hFFFF_FFFF);
    tick(8'h01, 0, 0, 0, 0);
    wr(8'h02, 32'hFFFF); wr(8'h01, 32'hFFFF_FFFF);
    tick(8'h01, 1, 0, 8'h03, 32'h1);
    rd(8'h03, "clr_vs_wrap", 1);

    // atomic read
    wr(8'h02, 1); wr(8'h01, 32'hFFFF_FFFF);
    tick(8'h01, 0, 1, 8'h01, 0);
    chk("atomic_lo", reg_read_data, 32'hFFFF_FFFF);
    repeat (2) tick(8'h01, 0, 0, 0, 0);
    tick(8'h01, 0, 1, 8'h02, 0);
    chk("atomic_hi", reg_read_data, 32'h1);

    // write priority over increment; out-of-range select
    tick(8'h01, 1, 0, 8'h01, 32'd100);
    rd(8'h01, "write_wins", 100);
    wr(8'h08, 32'h0901);
    repeat (5) tick(8'hFF, 0, 0, 0, 0);
    rd(8'h09, "sel_out_of_range", 0);

`ifdef PERF_THRESHOLD_EN
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h04, 3); wr(8'h05, 0); wr(8'h03, 3);
    wr(8'h00, 32'h0205);
    repeat (3) tick(8'h04, 0, 0, 0, 0);
    chk("thr_int_lag", overflow_int, 1'b0);
    tick(8'h00, 0, 0, 0, 0);
    chk("thr_int", overflow_int, 1'b1);
    rd(8'h03, "thr_status", 2);
`else
    rd(8'h04, "thr_lo_absent", 0);
    rd(8'h05, "thr_hi_absent", 0);
    wr(8'h00, 32'h0205);
    rd(8'h00, "ctrl_bit2_absent", 32'h0201);
    rd(8'h03, "status_bit1_absent", 1);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r, ci, off;
      if (n == 2000) begin
        do_reset();
        rd(8'h01, "midrun_reset", 0);
      end
      if (n == 0 || n == 2000) begin
        wr(8'hF8, 1);
        for (int i = 0; i < NC; i++) begin
          wr(8'(i * 8 + 2), 32'hFFFF);
          wr(8'(i * 8 + 1), 32'hFFFF_FFF0);
          wr(8'(i * 8), 32'((i % NE) << 8) | 32'h3);
        end
      end
      ev = 8'($urandom);
      we = $urandom_range(0, 9) < 3;
      re = $urandom_range(0, 9) < 4;
      r  = $urandom_range(0, 19);
      ci = $urandom_range(0, NC);
      off = $urandom_range(0, 7);
      if (r < 18)       ra = 8'(ci * 8 + off);
      else if (r == 18) ra = ($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hF9;
      else              ra = 8'($urandom);
      rw = $urandom;
      if (ra == 8'hF8) rw = {31'd0, 1'($urandom_range(0, 4) != 0)};
      else if (r < 18) begin
        case (off)
          0: begin
            rw = $urandom & 32'h0F07;
            if ($urandom_range(0, 3) != 0) rw[11] = 1'b0;
            rw[0] = ($urandom_range(0, 3) != 0);
          end
          1: if ($urandom_range(0, 1) != 0) rw = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          2: if ($urandom_range(0, 1) != 0) rw = 32'hFFFF;
          default: ;
        endcase
      end
      tick(ev, we, re, ra, rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
